// File: rtl/quad_dec_sysid_pkg.sv
// Shared word offsets, CAPS field layout and byte-merge helper for the Quad_Dec system-ID slave.
package quad_dec_sysid_pkg;

  localparam int unsigned WORD_ID       = 0;
  localparam int unsigned WORD_TS       = 1;
  localparam int unsigned WORD_CAPS     = 2;
  localparam int unsigned WORD_UPLO     = 3;
  localparam int unsigned WORD_UPHI     = 4;
  localparam int unsigned WORD_SCR_BASE = 6;

  localparam int unsigned CAPS_UPTIME_BIT = 0;
  localparam int unsigned CAPS_NSCR_LSB   = 8;
  localparam int unsigned CAPS_NSCR_W     = 8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/quad_dec_uptime_ctr.sv
// Prescaled free-running 64-bit uptime counter; wraps silently at 2^64-1.
module quad_dec_uptime_ctr #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [63:0] count
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_reg;
  logic [63:0]   count_reg;
  logic          tick;

  // With CLK_DIV=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick = (presc_reg == PW'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      count_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/quad_dec_sysid_regs.sv
// Avalon-MM system-ID/timestamp/caps slave with scratch bank; uptime counter and
// its snapshot shadow are built only when SYSID_UPTIME_EN is defined.
module quad_dec_sysid_regs
  import quad_dec_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1529059747,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned CLK_DIV     = 50
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int unsigned SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  if (ADDR_W < 3 || CLK_DIV < 1 || NUM_SCRATCH > (1 << ADDR_W) - 6) begin : g_param_err
    $error("quad_dec_sysid_regs: illegal ADDR_W/CLK_DIV/NUM_SCRATCH combination");
  end

  logic [31:0] addr_word;
  logic [31:0] rd_word;
  logic [31:0] caps_word;
  logic [31:0] scr_words [SCR_N];

  assign addr_word = 32'(address);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
  logic [63:0] uptime;
  logic [31:0] shadow_reg;

  quad_dec_uptime_ctr #(.CLK_DIV(CLK_DIV)) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .count   (uptime)
  );

  // Shadow latches the same sample returned by a LO read so a later HI read is coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) shadow_reg <= '0;
    else if (read && addr_word == 32'(WORD_UPLO)) shadow_reg <= uptime[63:32];
  end
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  always_comb begin
    caps_word = '0;
    caps_word[CAPS_NSCR_LSB +: CAPS_NSCR_W] = 8'(NUM_SCRATCH);
    caps_word[CAPS_UPTIME_BIT] = UPTIME_PRESENT;
  end

  // A write colliding with a read is dropped.
  for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr
    logic [31:0] word_reg;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) word_reg <= '0;
      else if (write && !read && addr_word == 32'(WORD_SCR_BASE + gi))
        word_reg <= byte_merge(word_reg, writedata, byteenable);
    end
    assign scr_words[gi] = word_reg;
  end
  if (NUM_SCRATCH == 0) begin : g_no_scr
    assign scr_words[0] = '0;
  end

  always_comb begin
    rd_word = '0;
    case (addr_word)
      32'(WORD_ID):   rd_word = SYSTEM_ID;
      32'(WORD_TS):   rd_word = TIMESTAMP;
      32'(WORD_CAPS): rd_word = caps_word;
`ifdef SYSID_UPTIME_EN
      32'(WORD_UPLO): rd_word = uptime[31:0];
      32'(WORD_UPHI): rd_word = shadow_reg;
`endif
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (addr_word == 32'(WORD_SCR_BASE + i)) rd_word = scr_words[i];
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_word;
    end
  end

endmodule
